// File: rtl/bus_uart_pkg.sv
// bus_uart_pkg: definitions shared by the bus_uart peripheral.
//   - register select codes (addr[3:2])
//   - STATUS register bit positions
//   - serial FSM state type, shared by the transmitter and the receiver
//   - divisor helper
package bus_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_TX_DROP   = 5;
    localparam int ST_FRAME_ERR = 6;
    localparam int ST_W         = 7;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // A programmed divisor of 0 behaves as 1 cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/bus_uart_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational read data (dout shows the
// head entry whenever empty=0).
// Ports:
//   clk, rst     clock, synchronous active-high reset (pointers only)
//   push, din    write request and data; accepted when not full, or when a
//                pop happens in the same cycle
//   pop, dout    read request and head data; ignored when empty
//   full, empty  status from pointer comparison
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // index bits match.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    // A pop while full frees the slot in the same cycle, so the push lands.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
        if (pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bus_uart.sv
// bus_uart: memory-mapped 8N1 UART on a bus_hub_2 device port.
//   +0 DATA   : write pushes a TX byte, read returns {rx_valid, rx_byte}
//   +4 STATUS : read-only flags, read clears TX_DROP and FRAME_ERR
//   +8 CLKDIV : clk cycles per bit, [15:0], byte-maskable
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   addr, wdata, wmask, ren, wen  hub request
//   rdata, ready                  registered response, one cycle after request
//   active                        combinational address decode hit
//   tx, rx                        serial lines (rx is asynchronous)
module bus_uart
    import bus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd217
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    output logic        tx,
    input  logic        rx
);
    logic [1:0]  sel;
    logic        rd_req, wr_req;
    logic [15:0] div_eff;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [ST_W-1:0] status;
    logic        unused_ok;

    uart_state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, clkdiv_q, clkdiv_d, rx_half;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic        tx_q, tx_d, rx_s1_q, rx_s2_q, rx_prev_q, rx_done, rx_ferr;
    logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
    logic        tx_drop_q, tx_drop_d, frame_err_q, frame_err_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    assign active    = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 32'd12);
    assign sel       = addr[3:2];
    assign rd_req    = ren && active;
    assign wr_req    = wen && active;
    assign div_eff   = eff_div(clkdiv_q);
    assign fifo_push = wr_req && (sel == REG_DATA) && wmask[0];
    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign tx        = tx_q;
    assign unused_ok = ^{wdata[31:16], wmask[3:2]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (wdata[7:0]),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Transmitter: every state holds for div_eff cycles; the divisor is
    // reloaded at each bit boundary so CLKDIV writes apply from the next bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        if (tx_state_q == IDLE) begin
            if (!fifo_empty) begin
                fifo_pop   = 1'b1;
                tx_state_d = START;
                tx_shift_d = fifo_dout;
                tx_cnt_d   = div_eff - 16'd1;
                tx_d       = 1'b0;
            end
        end else if (tx_cnt_q != 16'd0) begin
            tx_cnt_d = tx_cnt_q - 16'd1;
        end else begin
            tx_cnt_d = div_eff - 16'd1;
            case (tx_state_q)
                START: begin
                    tx_state_d = DATA;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
                DATA: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
                STOP: begin
                    // Chain straight into the next frame when data is queued.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_state_d = START;
                        tx_shift_d = fifo_dout;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = IDLE;
                        tx_d       = 1'b1;
                    end
                end
                default: tx_state_d = IDLE;
            endcase
        end
    end

    // Receiver: START waits half a bit to land all later samples mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        rx_half    = div_eff >> 1;
        case (rx_state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = START;
                    rx_cnt_d   = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;
                end
            end
            START: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (rx_s2_q) begin
                    rx_state_d = IDLE;
                end else begin
                    rx_state_d = DATA;
                    rx_bit_d   = 3'd0;
                    rx_cnt_d   = div_eff - 16'd1;
                end
            end
            DATA: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = div_eff - 16'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            STOP: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_state_d = IDLE;
                    rx_done    = rx_s2_q;
                    rx_ferr    = !rx_s2_q;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // Register file; read clears are applied before event sets so a
    // completion or error in the same cycle as the clearing read survives.
    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = fifo_full;
        status[ST_TX_EMPTY]   = fifo_empty;
        status[ST_RX_VALID]   = rx_valid_q;
        status[ST_RX_OVR]     = rx_ovr_q;
        status[ST_TX_BUSY]    = (tx_state_q != IDLE) || !fifo_empty;
        status[ST_TX_DROP]    = tx_drop_q;
        status[ST_FRAME_ERR]  = frame_err_q;

        rx_valid_d  = rx_valid_q;
        rx_ovr_d    = rx_ovr_q;
        rx_byte_d   = rx_byte_q;
        tx_drop_d   = tx_drop_q;
        frame_err_d = frame_err_q;
        clkdiv_d    = clkdiv_q;

        if (rd_req && (sel == REG_DATA)) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end
        if (rd_req && (sel == REG_STATUS)) begin
            tx_drop_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_done) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !(rd_req && (sel == REG_DATA))) rx_ovr_d = 1'b1;
        end
        if (rx_ferr) frame_err_d = 1'b1;
        if (fifo_push && fifo_full && !fifo_pop) tx_drop_d = 1'b1;
        if (wr_req && (sel == REG_CLKDIV)) begin
            if (wmask[0]) clkdiv_d[7:0]  = wdata[7:0];
            if (wmask[1]) clkdiv_d[15:8] = wdata[15:8];
        end

        ready_d = rd_req || wr_req;
        rdata_d = '0;
        if (ready_d) begin
            case (sel)
                REG_DATA:   rdata_d = {23'b0, rx_valid_q, rx_byte_q};
                REG_STATUS: rdata_d = {{(32-ST_W){1'b0}}, status};
                REG_CLKDIV: rdata_d = {16'b0, clkdiv_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_q        <= 1'b1;
            rx_state_q  <= IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            tx_drop_q   <= 1'b0;
            frame_err_q <= 1'b0;
            clkdiv_q    <= DEFAULT_DIV;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_q        <= tx_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_drop_q   <= tx_drop_d;
            frame_err_q <= frame_err_d;
            clkdiv_q    <= clkdiv_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
        rx_shift_q <= rx_shift_d;
        rx_byte_q  <= rx_byte_d;
    end

endmodule

// File: tb/tb_bus_uart.sv
// tb_bus_uart: directed bench for bus_uart with hand-computed expectations.
module tb_bus_uart;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        active;
    logic        tx;
    logic        rx = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic tx_log [1024];
    int   log_idx = 0;
    bit   log_en  = 1'b0;

    always #5 clk = ~clk;

    bus_uart #(.BASE_ADDR(BASE), .FIFO_DEPTH(16), .DEFAULT_DIV(16'd217)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .wmask (wmask),
        .ren   (ren),
        .wen   (wen),
        .rdata (rdata),
        .ready (ready),
        .active(active),
        .tx    (tx),
        .rx    (rx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output logic rdy, output logic [31:0] rd);
        @(negedge clk);
        ren = r; wen = w; addr = a; wdata = d; wmask = m;
        @(posedge clk);
        #1;
        rdy = ready;
        rd  = rdata;
        ren = 1'b0;
        wen = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic        rdy;
        logic [31:0] rd;
        xfer(1'b1, 1'b0, a, 32'h0, 4'h0, rdy, rd);
        check({tag, "_rdy"}, {31'b0, rdy}, 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic        rdy;
        logic [31:0] rd;
        xfer(1'b0, 1'b1, a, d, m, rdy, rd);
        check({tag, "_rdy"}, {31'b0, rdy}, 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (log_en && log_idx < 1024) begin
            tx_log[log_idx] = tx;
            log_idx++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  got;
        logic [7:0]  b;
        logic        rdy;
        logic [31:0] rd;
        int          st;
        bit          seen;

        // Reset state
        cyc(3);
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_status", BASE + 4, 32'h0000_0002);
        rd_chk("rst_clkdiv", BASE + 8, 32'h0000_00D9);
        check("rst_tx_idle", {31'b0, tx}, 32'd1);

        // Byte-masked divisor write, ignored DATA write, single frame
        wr_chk("div_wr", BASE + 8, 32'h0000_FF04, 4'b0001);
        rd_chk("div_rd", BASE + 8, 32'h0000_0004);
        wr_chk("data_nomask", BASE, 32'h0000_0055, 4'b0010);
        rd_chk("nomask_status", BASE + 4, 32'h0000_0002);
        wr_chk("a5_wr", BASE, 32'h0000_00A5, 4'b0001);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (tx == 1'b0) seen = 1'b1;
            else cyc(1);
        end
        check("a5_start_seen", {31'b0, seen}, 32'd1);
        cyc(2);
        got[0] = tx;
        for (int j = 1; j < 10; j++) begin
            cyc(4);
            got[j] = tx;
        end
        check("a5_frame", {22'b0, got}, {22'b0, 1'b1, 8'hA5, 1'b0});
        cyc(6);
        rd_chk("a5_idle_status", BASE + 4, 32'h0000_0002);

        // FIFO fill, overflow drop, back-to-back frames
        log_idx = 0;
        log_en  = 1'b1;
        for (int i = 0; i < 17; i++) wr_chk("q_wr", BASE, 32'h10 + i, 4'b0001);
        rd_chk("q_full", BASE + 4, 32'h0000_0011);
        wr_chk("q_drop_wr", BASE, 32'h0000_00EE, 4'b0001);
        rd_chk("q_drop", BASE + 4, 32'h0000_0031);
        rd_chk("q_drop_clr", BASE + 4, 32'h0000_0011);
        cyc(720);
        log_en = 1'b0;
        st = -1;
        for (int i = 0; i < 64; i++) if (st < 0 && tx_log[i] == 1'b0) st = i;
        check("q_start_found", {31'b0, st >= 0}, 32'd1);
        if (st < 0) st = 0;
        for (int k = 0; k < 17; k++) begin
            b = 8'h10 + 8'(k);
            for (int j = 0; j < 10; j++) got[j] = tx_log[st + 40*k + 4*j + 2];
            check("q_frame", {22'b0, got}, {22'b0, 1'b1, b, 1'b0});
        end
        check("q_no_dropped_frame", {31'b0, tx_log[st + 682]}, 32'd1);
        rd_chk("q_done_status", BASE + 4, 32'h0000_0002);

        // Receive path
        send_rx(8'h3C, 1'b1);
        rd_chk("rx_3c", BASE, 32'h0000_013C);
        rd_chk("rx_3c_again", BASE, 32'h0000_003C);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_chk("rx_ovr_status", BASE + 4, 32'h0000_000E);
        rd_chk("rx_22", BASE, 32'h0000_0122);
        send_rx(8'h55, 1'b1);
        send_rx(8'h77, 1'b0);
        rd_chk("rx_ferr_status", BASE + 4, 32'h0000_0046);
        rd_chk("rx_55_kept", BASE, 32'h0000_0155);
        rd_chk("rx_ferr_clr", BASE + 4, 32'h0000_0002);

        // Address decode boundaries
        @(negedge clk);
        addr = BASE + 12;
        #1 check("act_base12", {31'b0, active}, 32'd0);
        addr = BASE - 4;
        #1 check("act_below", {31'b0, active}, 32'd0);
        addr = BASE + 8;
        #1 check("act_base8", {31'b0, active}, 32'd1);
        xfer(1'b1, 1'b0, BASE + 12, 32'h0, 4'h0, rdy, rd);
        check("oob_rd_ready", {31'b0, rdy}, 32'd0);
        xfer(1'b0, 1'b1, BASE - 4, 32'h0000_00AA, 4'hF, rdy, rd);
        check("oob_wr_ready", {31'b0, rdy}, 32'd0);
        cyc(1);
        check("oob_ready_later", {31'b0, ready}, 32'd0);
        rd_chk("oob_no_push", BASE + 4, 32'h0000_0002);

        // Reset in the middle of a frame
        wr_chk("rst_wr0", BASE, 32'h0, 4'b0001);
        wr_chk("rst_wr1", BASE, 32'h0, 4'b0001);
        wr_chk("rst_wr2", BASE, 32'h0, 4'b0001);
        cyc(12);
        check("mid_frame_tx", {31'b0, tx}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", {31'b0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_mid_status", BASE + 4, 32'h0000_0002);
        rd_chk("rst_mid_clkdiv", BASE + 8, 32'h0000_00D9);
        cyc(5);
        check("rst_mid_tx_idle", {31'b0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_uart.md
Name: bus_uart

Overview:
- Memory-mapped 8N1 UART peripheral on one device port of bus_hub_2, alongside the program-memory and parallel_output devices.
- Consumes host bus transactions routed by the hub.
- Serialises written bytes from a TX FIFO onto `tx`, and deserialises `rx` into a single-entry receive buffer.
- Gives the SoC console I/O for firmware and the simulator.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte address of register 0. Must be 16-byte aligned and above program memory.
- FIFO_DEPTH, 16, TX FIFO entries. Must be a power of two, ≥2.
- DEFAULT_DIV, 16'd217, reset value of CLKDIV in clk cycles per bit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- addr  in  32  byte address from hub
- wdata  in  32  write data
- wmask  in  4  byte-lane write enables
- ren  in  1  read request
- wen  in  1  write request
- rdata  out  32  read data, valid when ready=1
- ready  out  1  transaction complete, one-cycle pulse
- active  out  1  combinational address decode hit
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous

Behaviour:
- Reset is synchronous, active-high; the only clock is clk.
- Reset values:
  - tx=1, ready=0, rdata=0.
  - FIFO empty, RX buffer empty, all sticky flags 0.
  - CLKDIV=DEFAULT_DIV, both FSMs IDLE.
- Reset mid-frame aborts the frame; tx returns high in the next cycle.
- active = (addr ≥ BASE_ADDR) && (addr < BASE_ADDR+12). It is purely combinational.
- Register select is addr[3:2]: 0=DATA, 1=STATUS, 2=CLKDIV. Select 3 is unreachable, because active is 0 there.
- Handshake:
  - ready <= (ren|wen)&active on every clock, giving exactly one cycle of latency.
  - rdata is registered in the same edge as ready. It is 0 when ready=0.
  - A request held high for N cycles is N transactions. The hub deasserts ren/wen after ready.
  - Side effects (push/pop/clear) occur on the request cycle, not the ready cycle.
  - ren and wen together: the write is performed; read data is returned as for a read of the same register.
- DATA register:
  - Write with wmask[0]=1 pushes wdata[7:0] into the TX FIFO.
  - If the FIFO is full, the byte is dropped and sticky TX_DROP is set. A write with wmask[0]=0 is ignored but still acked.
  - Read returns {23'b0, rx_valid, rx_byte} and clears rx_valid and RX_OVR.
- STATUS register (read-only):
  - Bit assignments: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 RX_OVR, bit4 tx_busy (FSM not IDLE or FIFO non-empty), bit5 TX_DROP, bit6 FRAME_ERR.
  - A read returns the values before the read, then clears TX_DROP and FRAME_ERR.
- CLKDIV register:
  - Bits [15:0] are RW, byte-masked by wmask[1:0]; the upper bits read 0.
  - An effective divisor of 0 is treated as 1.
  - A new value takes effect at the next bit boundary.
- TX FSM (IDLE→START→DATA→STOP→IDLE):
  - IDLE: if the FIFO is non-empty, pop and go to START. tx falls on the cycle after the pop.
  - Each state lasts CLKDIV cycles, counted by a 16-bit down-counter.
  - DATA shifts 8 bits LSB-first. STOP drives 1 for one bit.
  - Back-to-back bytes have no idle gap: STOP goes directly to START when the FIFO is non-empty.
- FIFO:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits. Pointers wrap naturally; full/empty come from MSB comparison.
  - Simultaneous push and pop while full is legal: the pop frees the slot in the same cycle, so the push succeeds.
- RX path and FSM (IDLE→START→DATA→STOP):
  - rx passes through a 2-flop synchroniser (reset value 1).
  - IDLE waits for a falling edge.
  - START waits CLKDIV/2 cycles, then re-samples. If rx is high, it is a false start and the FSM returns to IDLE.
  - DATA samples 8 bits mid-bit at CLKDIV spacing.
  - STOP samples at mid-bit:
    - If the sample is 1: write rx_byte and set rx_valid. If rx_valid was already 1, overwrite and set RX_OVR.
    - If the sample is 0: discard the byte and set FRAME_ERR.
  - STOP returns to IDLE right after the stop-bit sample.
  - A DATA read in the same cycle as an RX completion: the completion wins (rx_valid=1, new byte). RX_OVR is not set.

Decomposition:
- bus_uart_pkg holds:
  - register offsets (REG_DATA=2'd0, REG_STATUS=2'd1, REG_CLKDIV=2'd2)
  - STATUS bit indices
  - typedef enum uart_state_t {IDLE, START, DATA, STOP}, shared by the TX and RX FSMs
- Sub-module sync_fifo (params WIDTH=8, DEPTH; ports push/pop/din/dout/full/empty) is reusable by later peripherals.

Test Plan:
- Reset, then read STATUS at BASE_ADDR+4 → ready one cycle later; rdata=32'h0000_0002 (tx_empty only). tx stays 1.
- Write CLKDIV=4, then DATA=8'hA5 → tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4. STATUS bit4 clears afterwards.
- With CLKDIV=4, push 17 bytes back-to-back at FIFO_DEPTH=16:
  - STATUS shows tx_full once 16 bytes are queued and untransmitted.
  - The write that arrives while full sets TX_DROP=1.
  - 16 or 17 frames are emitted contiguously with no idle gap.
  - A STATUS read clears TX_DROP.
- Drive an 8N1 frame 8'h3C on rx at divisor 4, then read DATA → rdata=32'h0000_013C. A second read gives 32'h0000_003C (valid=0).
- Send two rx frames 8'h11, 8'h22 without reading → DATA=32'h0000_0122 and STATUS bit3=1 beforehand. Send a frame with stop bit 0 → FRAME_ERR=1, rx_valid unchanged.
- Access addr=BASE_ADDR+12 or BASE_ADDR-4 → active=0, ready never asserts. Assert rst mid-TX-frame → tx=1 and FIFO empty the next cycle.
